// File: rtl/id_ex_stage_pkg.sv
// Shared control-word layout for the decode and execute stages.
// Field indices, widths and the NOP encoding.
package id_ex_stage_pkg;

   localparam int CTL_W        = 12;
   localparam int CTL_REGWRITE = 11;
   localparam int CTL_DSEL_HI  = 10;
   localparam int CTL_DSEL_LO  = 9;
   localparam int CTL_MEMREAD  = 8;
   localparam int CTL_MEMWRITE = 7;
   localparam int CTL_ASEL_HI  = 6;
   localparam int CTL_ASEL_LO  = 4;
   localparam int CTL_ALUOP_HI = 3;
   localparam int CTL_ALUOP_LO = 1;
   localparam int CTL_ALUSEL   = 0;

   localparam logic [CTL_W-1:0] CTL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard compare between the EX slot and the decode slot.
// Purely combinational; also reused by the forwarding unit.
module hazard_detect #(
   parameter int RADDR_W = 5
) (
   input  logic               ex_valid,
   input  logic               ex_mem_read,
   input  logic [RADDR_W-1:0] ex_rd,
   input  logic               id_valid,
   input  logic [RADDR_W-1:0] id_rs1,
   input  logic [RADDR_W-1:0] id_rs2,
   output logic               hazard
);

   logic rd_live;
   logic src_hit;

   // x0 is never written, so a load to x0 can never cause a stall
   always_comb begin
      rd_live = (ex_rd != '0);
      src_hit = (ex_rd == id_rs1) | (ex_rd == id_rs2);
      hazard  = ex_valid & ex_mem_read & rd_live & id_valid & src_hit;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and bubble insertion.
// Priority: flush > hold > hazard > capture.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [CTL_W-1:0]   ctrSignalsIn,
   input  logic               validIn,
   input  logic [DATA_W-1:0]  pcIn,
   input  logic [DATA_W-1:0]  rs1DataIn,
   input  logic [DATA_W-1:0]  rs2DataIn,
   input  logic [DATA_W-1:0]  immIn,
   input  logic [RADDR_W-1:0] rs1AddrIn,
   input  logic [RADDR_W-1:0] rs2AddrIn,
   input  logic [RADDR_W-1:0] rdAddrIn,
   input  logic               flushIn,
   input  logic               holdIn,
   output logic [CTL_W-1:0]   ctrSignalsOut,
   output logic               validOut,
   output logic [DATA_W-1:0]  pcOut,
   output logic [DATA_W-1:0]  rs1DataOut,
   output logic [DATA_W-1:0]  rs2DataOut,
   output logic [DATA_W-1:0]  immOut,
   output logic [RADDR_W-1:0] rs1AddrOut,
   output logic [RADDR_W-1:0] rs2AddrOut,
   output logic [RADDR_W-1:0] rdAddrOut,
   output logic               stallOut,
   output logic [CNT_W-1:0]   bubbleCnt
);

   logic hazard;
   logic bubble;
   logic count_en;

   hazard_detect #(
      .RADDR_W (RADDR_W)
   ) u_hazard (
      .ex_valid    (validOut),
      .ex_mem_read (ctrSignalsOut[CTL_MEMREAD]),
      .ex_rd       (rdAddrOut),
      .id_valid    (validIn),
      .id_rs1      (rs1AddrIn),
      .id_rs2      (rs2AddrIn),
      .hazard      (hazard)
   );

   // Stall request and bubble selection for this edge
   always_comb begin
      stallOut = hazard & ~flushIn & ~holdIn;
      bubble   = flushIn | (~holdIn & hazard);
      count_en = bubble & validIn & (bubbleCnt != '1);
   end

   // Pipeline register bank with flush/hold/bubble priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrSignalsOut <= CTL_NOP;
         validOut      <= 1'b0;
         pcOut         <= '0;
         rs1DataOut    <= '0;
         rs2DataOut    <= '0;
         immOut        <= '0;
         rs1AddrOut    <= '0;
         rs2AddrOut    <= '0;
         rdAddrOut     <= '0;
      end else if (bubble) begin
         ctrSignalsOut <= CTL_NOP;
         validOut      <= 1'b0;
         pcOut         <= '0;
         rs1DataOut    <= '0;
         rs2DataOut    <= '0;
         immOut        <= '0;
         rs1AddrOut    <= '0;
         rs2AddrOut    <= '0;
         rdAddrOut     <= '0;
      end else if (!holdIn) begin
         ctrSignalsOut <= validIn ? ctrSignalsIn : CTL_NOP;
         validOut      <= validIn;
         pcOut         <= pcIn;
         rs1DataOut    <= rs1DataIn;
         rs2DataOut    <= rs2DataIn;
         immOut        <= immIn;
         rs1AddrOut    <= rs1AddrIn;
         rs2AddrOut    <= rs2AddrIn;
         rdAddrOut     <= rdAddrIn;
      end
   end

   // Saturating count of bubbles inserted over a real instruction
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bubbleCnt <= '0;
      else if (count_en)
         bubbleCnt <= bubbleCnt + 1'b1;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pipelining, load-use stall,
// flush/hold priority, async reset and counter saturation.
module tb_id_ex_stage;

   logic        clk;
   logic        rst;
   logic [11:0] ctr_in;
   logic        valid_in;
   logic [31:0] pc_in, rs1d_in, rs2d_in, imm_in;
   logic [4:0]  rs1_in, rs2_in, rd_in;
   logic        flush, hold;
   logic [11:0] ctr_out;
   logic        valid_out;
   logic [31:0] pc_out, rs1d_out, rs2d_out, imm_out;
   logic [4:0]  rs1_out, rs2_out, rd_out;
   logic        stall;
   logic [15:0] cnt;

   int n_checks = 0;
   int n_fail   = 0;

   id_ex_stage dut (
      .clk           (clk),
      .rst           (rst),
      .ctrSignalsIn  (ctr_in),
      .validIn       (valid_in),
      .pcIn          (pc_in),
      .rs1DataIn     (rs1d_in),
      .rs2DataIn     (rs2d_in),
      .immIn         (imm_in),
      .rs1AddrIn     (rs1_in),
      .rs2AddrIn     (rs2_in),
      .rdAddrIn      (rd_in),
      .flushIn       (flush),
      .holdIn        (hold),
      .ctrSignalsOut (ctr_out),
      .validOut      (valid_out),
      .pcOut         (pc_out),
      .rs1DataOut    (rs1d_out),
      .rs2DataOut    (rs2d_out),
      .immOut        (imm_out),
      .rs1AddrOut    (rs1_out),
      .rs2AddrOut    (rs2_out),
      .rdAddrOut     (rd_out),
      .stallOut      (stall),
      .bubbleCnt     (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [11:0] c, input logic [31:0] pc,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d);
      ctr_in   = c;
      valid_in = 1'b1;
      pc_in    = pc;
      rs1d_in  = pc + 32'h10;
      rs2d_in  = pc + 32'h20;
      imm_in   = pc + 32'h30;
      rs1_in   = s1;
      rs2_in   = s2;
      rd_in    = d;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctr"}, 64'(ctr_out), 64'h0);
      check({tag, "_valid"}, 64'(valid_out), 64'h0);
      check({tag, "_pc"}, 64'(pc_out), 64'h0);
      check({tag, "_rs1d"}, 64'(rs1d_out), 64'h0);
      check({tag, "_rs2d"}, 64'(rs2d_out), 64'h0);
      check({tag, "_imm"}, 64'(imm_out), 64'h0);
      check({tag, "_rd"}, 64'(rd_out), 64'h0);
      check({tag, "_stall"}, 64'(stall), 64'h0);
      check({tag, "_cnt"}, 64'(cnt), 64'h0);
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      hold = 1'b0;
      drive(12'h0, 32'h0, 5'd0, 5'd0, 5'd0);
      valid_in = 1'b0;
      #2;
      check_zero("reset");
      step();
      step();
      rst = 1'b0;

      // plain add stream, one cycle latency
      for (int i = 0; i < 3; i++) begin
         drive(12'h803, 32'h100 + 32'(4 * i), 5'd1, 5'd2, 5'(3 + i));
         #1;
         check("add_stall", 64'(stall), 64'h0);
         step();
         check("add_ctr", 64'(ctr_out), 64'h803);
         check("add_valid", 64'(valid_out), 64'h1);
         check("add_pc", 64'(pc_out), 64'h100 + 64'(4 * i));
         check("add_imm", 64'(imm_out), 64'h130 + 64'(4 * i));
         check("add_rd", 64'(rd_out), 64'(3 + i));
      end

      // load-use: lw x5 then add rs1=x5
      drive(12'hD02, 32'h200, 5'd1, 5'd2, 5'd5);
      step();
      check("lw_ctr", 64'(ctr_out), 64'hD02);
      drive(12'h803, 32'h204, 5'd5, 5'd6, 5'd7);
      #1;
      check("lu_stall", 64'(stall), 64'h1);
      step();
      check("lu_bub_ctr", 64'(ctr_out), 64'h0);
      check("lu_bub_valid", 64'(valid_out), 64'h0);
      check("lu_cnt", 64'(cnt), 64'h1);
      check("lu_stall_off", 64'(stall), 64'h0);
      step();
      check("lu_add_ctr", 64'(ctr_out), 64'h803);
      check("lu_add_pc", 64'(pc_out), 64'h204);
      check("lu_add_rs1", 64'(rs1_out), 64'h5);
      check("lu_cnt2", 64'(cnt), 64'h1);

      // load to x0 never stalls
      drive(12'hD02, 32'h300, 5'd1, 5'd2, 5'd0);
      step();
      drive(12'h803, 32'h304, 5'd0, 5'd0, 5'd8);
      #1;
      check("x0_stall", 64'(stall), 64'h0);
      step();
      check("x0_ctr", 64'(ctr_out), 64'h803);
      check("x0_pc", 64'(pc_out), 64'h304);
      check("x0_cnt", 64'(cnt), 64'h1);

      // flush wins over hazard and hold
      drive(12'hD02, 32'h400, 5'd1, 5'd2, 5'd5);
      step();
      drive(12'h803, 32'h404, 5'd5, 5'd6, 5'd7);
      flush = 1'b1;
      hold = 1'b1;
      #1;
      check("fl_stall", 64'(stall), 64'h0);
      step();
      check("fl_ctr", 64'(ctr_out), 64'h0);
      check("fl_valid", 64'(valid_out), 64'h0);
      check("fl_pc", 64'(pc_out), 64'h0);
      check("fl_cnt", 64'(cnt), 64'h2);
      flush = 1'b0;
      hold = 1'b0;

      // hold freezes everything for three cycles
      drive(12'h803, 32'h500, 5'd1, 5'd2, 5'd3);
      step();
      hold = 1'b1;
      drive(12'hD02, 32'h600, 5'd9, 5'd9, 5'd9);
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_ctr", 64'(ctr_out), 64'h803);
         check("hold_pc", 64'(pc_out), 64'h500);
         check("hold_rd", 64'(rd_out), 64'h3);
         check("hold_cnt", 64'(cnt), 64'h2);
      end
      hold = 1'b0;

      // invalid decode slot forces a NOP control word
      drive(12'h803, 32'h700, 5'd1, 5'd2, 5'd3);
      valid_in = 1'b0;
      step();
      check("inv_ctr", 64'(ctr_out), 64'h0);
      check("inv_valid", 64'(valid_out), 64'h0);
      check("inv_pc", 64'(pc_out), 64'h700);
      check("inv_cnt", 64'(cnt), 64'h2);

      // async reset mid-stream, no edge needed
      drive(12'h803, 32'h800, 5'd1, 5'd2, 5'd3);
      step();
      check("pre_rst_valid", 64'(valid_out), 64'h1);
      #2;
      rst = 1'b1;
      #1;
      check_zero("midrst");
      step();
      rst = 1'b0;

      // drive the counter to saturation with back-to-back flushes
      flush = 1'b1;
      repeat (65535) step();
      check("sat_full", 64'(cnt), 64'hFFFF);
      step();
      check("sat_hold", 64'(cnt), 64'hFFFF);
      step();
      check("sat_hold2", 64'(cnt), 64'hFFFF);
      flush = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
